// File: rtl/ram2_fifo_ctrl_if.sv
// Stream and RAM-side signal bundle for the dual-port RAM FIFO controller.
// The slave modport is the controller's view; master is the surrounding
// environment (upstream source, downstream sink and RAM).
interface ram2_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 1
);
  // upstream word stream
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  // downstream word stream
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  // RAM write/read ports
  logic [DATA_WIDTH-1:0] ram_data;
  logic [ADDR_WIDTH-1:0] ram_wraddress;
  logic                  ram_wren;
  logic [ADDR_WIDTH-1:0] ram_rdaddress;
  logic [DATA_WIDTH-1:0] ram_q;
  // occupancy: unfetched RAM words plus the fetch/output stage word
  logic [ADDR_WIDTH+1:0] level;

  modport slave (
    input  in_data, in_valid, out_ready, ram_q,
    output in_ready, out_data, out_valid,
    output ram_data, ram_wraddress, ram_wren, ram_rdaddress, level
  );

  modport master (
    output in_data, in_valid, out_ready, ram_q,
    input  in_ready, out_data, out_valid,
    input  ram_data, ram_wraddress, ram_wren, ram_rdaddress, level
  );
endinterface

// File: rtl/ram2_fifo_ctrl.sv
// FIFO controller around an external dual-port RAM (both RAM clocks on clk).
// Writes accepted words into the RAM, fetches them back in order and holds
// each on a registered valid/ready output stage.
module ram2_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  ram2_fifo_ctrl_if.slave  bus
);

  // RAM depth D = 2**ADDR_WIDTH, built without a 32-bit shift
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_VALID} state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  accept;
  logic                  issue;

  // Write side: a word is accepted whenever the RAM has a free slot.
  assign bus.in_ready      = (ram_cnt < DEPTH);
  assign accept            = bus.in_valid & bus.in_ready;
  assign bus.ram_wren      = accept;
  assign bus.ram_wraddress = wr_ptr;
  assign bus.ram_data      = bus.in_data;

  // Read side: the RAM always looks at the oldest unfetched slot; ram_q
  // is valid one clock after an issue, when the FSM sits in S_FETCH.
  assign bus.ram_rdaddress = rd_ptr;

  assign bus.out_valid = (state == S_VALID);
  assign bus.out_data  = out_data_q;
  assign bus.level     = {1'b0, ram_cnt} + {{(ADDR_WIDTH+1){1'b0}}, (state != S_IDLE)};

  // Next-state and issue decision for the fetch/output stage.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_next = state;
    issue      = 1'b0;
    case (state)
      S_IDLE: begin
        if (ram_cnt != '0) begin
          issue      = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_FETCH: state_next = S_VALID;
      S_VALID: begin
        if (bus.out_ready) begin
          if (ram_cnt != '0) begin
            issue      = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register plus pointers, RAM occupancy and the output data stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ram_cnt    <= '0;
      // NOTE: RAM contents are deliberately not cleared on reset; zeroing
      // ram_cnt alone guarantees stale words are never fetched.
      out_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here updates from
      // the pre-edge values, independent of statement order.
      state <= state_next;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (issue)  rd_ptr <= rd_ptr + 1'b1;
      case ({accept, issue})
        2'b10:   ram_cnt <= ram_cnt + 1'b1;
        2'b01:   ram_cnt <= ram_cnt - 1'b1;
        default: ram_cnt <= ram_cnt;
      endcase
      if (state == S_FETCH) out_data_q <= bus.ram_q;
    end
  end

endmodule
